// File: rtl/cmp_pkg.sv
// Shared types, result-bit encoding and helpers for the pipelined magnitude comparator.
package cmp_pkg;

  localparam int CMP_LT = 0;
  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;

  // {gt, eq, lt}, indexed with CMP_*
  typedef logic [2:0] cmp_res_t;

  function automatic int cmp_latency(input int order, input int limit, input int stage);
    return (order - limit + stage - 1) / stage;
  endfunction

  // Operand is MSB-aligned in 64 bits so one helper serves every legal width.
  function automatic logic [63:0] sign_fix(input logic [63:0] x, input logic signed_mode);
    return {x[63] ^ signed_mode, x[62:0]};
  endfunction

endpackage

// File: rtl/cmp_pipe_if.sv
// Operand/result handshake bundle between the ALU operand path and the comparator.
interface cmp_pipe_if #(parameter int W = 8);

  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic         out_lt;
  logic         out_eq;
  logic         out_gt;
  logic [W-1:0] out_min;
  logic [W-1:0] out_max;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_lt, out_eq, out_gt, out_min, out_max
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_lt, out_eq, out_gt, out_min, out_max
  );

endinterface

// File: rtl/cmp_merge.sv
// One merge node of the comparator tree: the high half decides unless it is equal.
module cmp_merge
  import cmp_pkg::*;
(
  input  cmp_res_t i_h,
  input  cmp_res_t i_l,
  output cmp_res_t o_m
);

  always_comb begin
    // NOTE: assign a default to everything first so no path leaves o_m unassigned (no latch).
    o_m         = '0;
    o_m[CMP_LT] = i_h[CMP_EQ] ? i_l[CMP_LT] : i_h[CMP_LT];
    o_m[CMP_GT] = i_h[CMP_EQ] ? i_l[CMP_GT] : i_h[CMP_GT];
    o_m[CMP_EQ] = i_h[CMP_EQ] & i_l[CMP_EQ];
  end

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined signed/unsigned magnitude comparator: leaf compares, a registered merge tree,
// and min/max selection in the last stage, with valid/ready flow control per stage.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int LIMIT = 0,
  parameter int STAGE = 1
) (
  input logic     clk,
  input logic     rst_n,
  cmp_pipe_if.slave bus
);

  localparam int W   = 1 << ORDER;
  localparam int LW  = 1 << LIMIT;
  localparam int D   = ORDER - LIMIT;
  localparam int NL  = 1 << D;
  localparam int L   = cmp_latency(ORDER, LIMIT, STAGE);
  localparam int PAD = 64 - W;

  logic [L-1:0]        w_valid;
  logic [L:0]          w_ready;
  logic [L-1:0]        w_load;
  logic [L-1:0][W-1:0] w_a_q;
  logic [L-1:0][W-1:0] w_b_q;
  logic [W-1:0]        w_a_fix;
  logic [W-1:0]        w_b_fix;
  logic                w_final_gt;

  // All tree levels packed back to back: level j has 2**(D-j) nodes at offset 2*NL - 2*2**(D-j).
  logic [2*NL-2:0]     w_q_lt;
  logic [2*NL-2:0]     w_q_eq;
  logic [2*NL-2:0]     w_q_gt;

  // Flipping the MSB maps two's complement order onto unsigned order.
  assign w_a_fix = W'(sign_fix(64'(bus.in_a) << PAD, bus.in_signed) >> PAD);
  assign w_b_fix = W'(sign_fix(64'(bus.in_b) << PAD, bus.in_signed) >> PAD);

  assign w_ready[L] = bus.out_ready;

  for (genvar k = 0; k < L; k++) begin : g_stg
    logic         w_v_in;
    logic [W-1:0] w_a_in;
    logic [W-1:0] w_b_in;
    logic [W-1:0] w_a_nxt;
    logic [W-1:0] w_b_nxt;
    logic         r_valid;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;

    if (k == 0) begin : g_src_in
      assign w_v_in = bus.in_valid;
      assign w_a_in = bus.in_a;
      assign w_b_in = bus.in_b;
    end else begin : g_src_reg
      assign w_v_in = w_valid[k-1];
      assign w_a_in = w_a_q[k-1];
      assign w_b_in = w_b_q[k-1];
    end

    // The last stage stores min/max in the a/b slots; a is chosen when equal.
    if (k == L-1) begin : g_minmax
      assign w_a_nxt = w_final_gt ? w_b_in : w_a_in;
      assign w_b_nxt = w_final_gt ? w_a_in : w_b_in;
    end else begin : g_carry
      assign w_a_nxt = w_a_in;
      assign w_b_nxt = w_b_in;
    end

    assign w_ready[k] = !r_valid | w_ready[k+1];
    assign w_load[k]  = w_ready[k] & w_v_in;

    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: data registers are reset as well, because out_min/out_max must read 0 after reset.
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_a     <= '0;
        r_b     <= '0;
      end else begin
        if (w_ready[k]) r_valid <= w_v_in;
        if (w_load[k]) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
      end
    end

    assign w_valid[k] = r_valid;
    assign w_a_q[k]   = r_a;
    assign w_b_q[k]   = r_b;
  end

  for (genvar j = 0; j <= D; j++) begin : g_lvl
    localparam int NJ  = 1 << (D - j);
    localparam int OFF = 2*NL - 2*NJ;

    if (j == 0) begin : g_leaf
      for (genvar n = 0; n < NJ; n++) begin : g_n
        assign w_q_lt[n] = w_a_fix[n*LW +: LW] <  w_b_fix[n*LW +: LW];
        assign w_q_eq[n] = w_a_fix[n*LW +: LW] == w_b_fix[n*LW +: LW];
        assign w_q_gt[n] = w_a_fix[n*LW +: LW] >  w_b_fix[n*LW +: LW];
      end
    end else begin : g_merge
      localparam int POFF = 2*NL - 4*NJ;
      localparam int S    = (j - 1) / STAGE;
      localparam bit REG  = ((j % STAGE) == 0) || (j == D);

      logic [NJ-1:0] w_lt;
      logic [NJ-1:0] w_eq;
      logic [NJ-1:0] w_gt;

      for (genvar n = 0; n < NJ; n++) begin : g_n
        cmp_res_t w_m;
        cmp_merge u_merge (
          .i_h ({w_q_gt[POFF+2*n+1], w_q_eq[POFF+2*n+1], w_q_lt[POFF+2*n+1]}),
          .i_l ({w_q_gt[POFF+2*n],   w_q_eq[POFF+2*n],   w_q_lt[POFF+2*n]}),
          .o_m (w_m)
        );
        assign w_lt[n] = w_m[CMP_LT];
        assign w_eq[n] = w_m[CMP_EQ];
        assign w_gt[n] = w_m[CMP_GT];
      end

      if (REG) begin : g_reg
        logic [NJ-1:0] r_lt;
        logic [NJ-1:0] r_eq;
        logic [NJ-1:0] r_gt;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_lt <= '0;
            r_eq <= '0;
            r_gt <= '0;
          end else if (w_load[S]) begin
            r_lt <= w_lt;
            r_eq <= w_eq;
            r_gt <= w_gt;
          end
        end

        assign w_q_lt[OFF +: NJ] = r_lt;
        assign w_q_eq[OFF +: NJ] = r_eq;
        assign w_q_gt[OFF +: NJ] = r_gt;
      end else begin : g_comb
        assign w_q_lt[OFF +: NJ] = w_lt;
        assign w_q_eq[OFF +: NJ] = w_eq;
        assign w_q_gt[OFF +: NJ] = w_gt;
      end

      if (j == D) begin : g_final
        assign w_final_gt = w_gt[0];
      end
    end
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.out_valid = w_valid[L-1];
  assign bus.out_lt    = w_q_lt[2*NL-2];
  assign bus.out_eq    = w_q_eq[2*NL-2];
  assign bus.out_gt    = w_q_gt[2*NL-2];
  assign bus.out_min   = w_a_q[L-1];
  assign bus.out_max   = w_b_q[L-1];

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard bench for cmp_pipe (ORDER=3, LIMIT=0, STAGE=1): directed pairs with hand-computed
// results are queued on acceptance and popped by an independent output monitor.
module tb_cmp_pipe;
  import cmp_pkg::*;

  localparam int ORDER = 3;
  localparam int LIMIT = 0;
  localparam int STAGE = 1;
  localparam int W     = 1 << ORDER;
  localparam int L     = 3;

  // Expected result vectors, {gt, eq, lt}
  localparam cmp_res_t R_LT = 3'b001;
  localparam cmp_res_t R_EQ = 3'b010;
  localparam cmp_res_t R_GT = 3'b100;

  typedef struct {
    cmp_res_t     res;
    logic [W-1:0] mn;
    logic [W-1:0] mx;
    int           due;
    bit           chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_out = 0;
  exp_t exp_q[$];

  cmp_pipe_if #(.W(W)) bus ();

  cmp_pipe #(.ORDER(ORDER), .LIMIT(LIMIT), .STAGE(STAGE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Starts just after a rising edge; returns just after the edge that took the pair.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                      input cmp_res_t res, input logic [W-1:0] mn, input logic [W-1:0] mx,
                      input bit chk_lat);
    int   k;
    exp_t e;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = sgn;
    bus.in_valid  = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 200);
    if (!bus.in_ready) begin
      check("in_ready_timeout", 64'd0, 64'd1);
    end else begin
      e = '{res, mn, mx, cyc + L, chk_lat};
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops on every output transfer and checks holds across stalls.
  logic         stalled = 1'b0;
  cmp_res_t     h_res;
  logic [W-1:0] h_mn;
  logic [W-1:0] h_mx;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (stalled) begin
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_res",   64'({bus.out_gt, bus.out_eq, bus.out_lt}), 64'(h_res));
      check("hold_min",   64'(bus.out_min), 64'(h_mn));
      check("hold_max",   64'(bus.out_max), 64'(h_mx));
    end
    stalled <= bus.out_valid && !bus.out_ready;
    h_res   <= {bus.out_gt, bus.out_eq, bus.out_lt};
    h_mn    <= bus.out_min;
    h_mx    <= bus.out_max;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 64'({bus.out_gt, bus.out_eq, bus.out_lt}), 64'(mon_e.res));
        check("min",    64'(bus.out_min), 64'(mon_e.mn));
        check("max",    64'(bus.out_max), 64'(mon_e.mx));
        if (mon_e.chk_lat) check("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset for three cycles, release between edges
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready",  64'(bus.in_ready), 64'd1);
    check("rel_out_valid", 64'(bus.out_valid), 64'd0);
    check("rel_res",       64'({bus.out_gt, bus.out_eq, bus.out_lt}), 64'd0);
    check("rel_min",       64'(bus.out_min), 64'd0);
    check("rel_max",       64'(bus.out_max), 64'd0);

    // Unsigned vs signed interpretation of the same operands
    send(8'h80, 8'h7F, 1'b0, R_GT, 8'h7F, 8'h80, 1'b1);
    drain();
    send(8'h80, 8'h7F, 1'b1, R_LT, 8'h80, 8'h7F, 1'b1);
    send(8'hFF, 8'h01, 1'b1, R_LT, 8'hFF, 8'h01, 1'b1);
    send(8'h80, 8'h80, 1'b1, R_EQ, 8'h80, 8'h80, 1'b1);
    drain();

    // Back-to-back throughput, one result per cycle
    send(8'h5A, 8'h5A, 1'b0, R_EQ, 8'h5A, 8'h5A, 1'b1);
    send(8'h00, 8'hFF, 1'b0, R_LT, 8'h00, 8'hFF, 1'b1);
    send(8'hFF, 8'h00, 1'b0, R_GT, 8'h00, 8'hFF, 1'b1);
    send(8'h10, 8'h11, 1'b0, R_LT, 8'h10, 8'h11, 1'b1);
    drain();

    // Backpressure: pipe fills to L entries, stalls, then drains in order
    base = n_acc;
    fork
      begin
        send(8'h01, 8'h02, 1'b1, R_LT, 8'h01, 8'h02, 1'b0);
        send(8'h33, 8'h33, 1'b0, R_EQ, 8'h33, 8'h33, 1'b0);
        send(8'h7F, 8'h80, 1'b1, R_GT, 8'h80, 8'h7F, 1'b0);
        send(8'hC0, 8'h3F, 1'b0, R_GT, 8'h3F, 8'hC0, 1'b0);
        send(8'hFE, 8'hFD, 1'b1, R_GT, 8'hFD, 8'hFE, 1'b0);
      end
      begin
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_accepted", 64'(n_acc - base), 64'd3);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_total", 64'(n_acc - base), 64'd5);

    // Asynchronous reset with two pairs in flight
    send(8'h12, 8'h34, 1'b0, R_LT, 8'h12, 8'h34, 1'b0);
    send(8'h99, 8'h11, 1'b0, R_GT, 8'h11, 8'h99, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    base = n_out;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2*L) @(negedge clk);
    check("no_stale_out", 64'(n_out - base), 64'd0);

    // Pipe still works after the mid-run reset
    @(posedge clk);
    #1;
    send(8'h3C, 8'hC3, 1'b1, R_GT, 8'hC3, 8'h3C, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
